alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Clocked, handshaked successor to the combinational ALU.
- Accepts one operation per valid/ready transfer and holds its result in an output register until the consumer takes it.
- Adds unsigned subtract, a multi-cycle shift-add multiply, comparators and shifters, plus an illegal-command flag.
- Sits between the operand/command source (e.g. a decode stage) and the result sink.

Parameters:
- SIZE, 8, operand width in bits (>=2); result width is 2*SIZE.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  command/operands valid
- in_ready  out  1  block can accept a command this cycle
- command  in  4  operation select
- a  in  SIZE  operand A
- b  in  SIZE  operand B
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer takes the result this cycle
- result  out  2*SIZE  registered result
- overflow  out  1  registered overflow/carry/borrow flag
- illegal  out  1  registered flag: command was 12-15
- busy  out  1  multiply in progress

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; out_valid=0, result=0, overflow=0, illegal=0, busy=0.
  - Reset mid-multiply aborts the operation; no result is produced.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready = (state==IDLE) & (!out_valid | out_ready); combinational, no dependence on in_valid.
- Single-cycle ops (command 0-6, 8-15):
  - Accepted at edge N; result, overflow, illegal and out_valid=1 are registered at edge N.
  - Back-to-back throughput is 1/cycle while out_ready=1.
- Multiply (command 7):
  - Accepted at edge N; state becomes MUL, busy=1, operands latched, counter=0, partial product=0.
  - Each cycle adds (b_latched[counter] ? a<<counter : 0) into the partial product.
  - After SIZE iterations (edge N+SIZE): result loaded, out_valid=1, state=IDLE, busy=0.
  - in_ready=0 throughout MUL.
- Output hold: result, overflow and illegal stay stable while out_valid & !out_ready.
- Clearing out_valid: an output transfer with no simultaneous input transfer clears out_valid next edge. A simultaneous input and output transfer of a single-cycle op overwrites the register with out_valid staying 1.
- Operation encodings, all results 2*SIZE wide:
  - 0 AND, 1 OR, 2 XOR: zero-extended, overflow=0.
  - 3 NOT: zero-extended ~a, overflow=0.
  - 4 unsigned add: result = zext(a)+zext(b) (SIZE+1 bits significant); overflow = carry out of bit SIZE-1.
  - 5 signed add: result = sign-extended true sum sext(a)+sext(b); overflow = SIZE-bit signed overflow.
  - 6 unsigned subtract: result = zext((a-b) mod 2^SIZE); overflow = borrow (a<b).
  - 7 unsigned multiply: full 2*SIZE product; overflow = (product[2*SIZE-1:SIZE] != 0).
  - 8 unsigned compare, 9 signed compare: result[0]=a<b, result[1]=a==b, result[2]=a>b, other bits 0; overflow=0.
  - 10 shift left: zext(a) << b; b >= 2*SIZE gives 0; overflow=0.
  - 11 logical shift right: a >> b; b >= SIZE gives 0; overflow=0.
  - 12-15: result=0, overflow=0, illegal=1; handled as single-cycle.
- illegal is 0 for every legal command.
- in_valid while in_ready=0 is not a transfer; the source must hold its values.

Decomposition:
- Package alu_pkg holds:
  - enum typedef alu_cmd_e (4-bit; AND=0 ... SHR=11).
  - state typedef alu_state_e {IDLE, MUL}.
  - localparam CMD_LAST_LEGAL=11.
- Sub-module alu_mul_seq: the shift-add multiplier with start/done, parameter SIZE.
- Single-cycle ops stay as combinational logic inside alu_seq.

Test Plan (SIZE=8):
- Reset mid-multiply: assert reset_n=0 during a MUL -> all outputs 0, in_ready=1 after release, no out_valid.
- Unsigned add: a=0xFF, b=0x01, cmd 4 -> result=0x0100, overflow=1, one cycle latency.
- Signed add: a=0x7F, b=0x01, cmd 5 -> result=0x0080, overflow=1.
- Signed compare: a=0x80, b=0x01, cmd 9 -> result=0x0001.
- Multiply: a=0xFF, b=0xFF, cmd 7 -> busy=1 for 8 cycles, then result=0xFE01, overflow=1, in_ready=0 while busy.
- Backpressure: hold out_ready=0 after a result -> result stable, in_ready=0.
- Back-to-back streaming: cmds 0,1,2 with out_ready=1 -> one result per cycle.
- Illegal command: cmd 13 -> illegal=1, result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    CMD_AND  = 4'd0,
    CMD_OR   = 4'd1,
    CMD_XOR  = 4'd2,
    CMD_NOT  = 4'd3,
    CMD_ADD  = 4'd4,
    CMD_ADDS = 4'd5,
    CMD_SUB  = 4'd6,
    CMD_MUL  = 4'd7,
    CMD_CMPU = 4'd8,
    CMD_CMPS = 4'd9,
    CMD_SHL  = 4'd10,
    CMD_SHR  = 4'd11
  } alu_cmd_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

  localparam int unsigned CMD_LAST_LEGAL = 11;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per cycle, SIZE cycles.
// done/product are combinational on the final iteration so the caller can
// capture the full product on the same edge as the last accumulate.
module alu_mul_seq #(
  parameter int unsigned SIZE = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              done,
  output logic [2*SIZE-1:0] product
);

  localparam int unsigned CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  logic              running;
  logic [CW-1:0]     cnt;
  logic [2*SIZE-1:0] a_q;
  logic [SIZE-1:0]   b_q;
  logic [2*SIZE-1:0] acc;
  logic [2*SIZE-1:0] addend;
  logic [2*SIZE-1:0] next_acc;

  // Next partial product and completion of the last iteration
  always_comb begin
    addend   = b_q[cnt] ? (a_q << cnt) : '0;
    next_acc = acc + addend;
    done     = running && (cnt == LAST);
    product  = next_acc;
  end

  // Operand latch, iteration counter and accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      a_q     <= {{SIZE{1'b0}}, a};
      b_q     <= b;
      acc     <= '0;
    end else if (running) begin
      acc <= next_acc;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops plus a multi-cycle multiply,
// result held in an output register until the consumer takes it.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned SIZE = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        command,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] result,
  output logic              overflow,
  output logic              illegal,
  output logic              busy
);

  localparam int unsigned RW = 2 * SIZE;

  alu_state_e      state;
  logic            in_fire;
  logic            out_fire;
  logic            mul_start;
  logic            mul_done;
  logic [RW-1:0]   mul_product;
  logic [RW-1:0]   op_result;
  logic            op_overflow;
  logic            op_illegal;
  logic [SIZE:0]   sum_u;
  logic [SIZE:0]   sum_s;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign mul_start = in_fire && (command == CMD_MUL);

  alu_mul_seq #(.SIZE(SIZE)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle operation results
  always_comb begin
    op_result   = '0;
    op_overflow = 1'b0;
    op_illegal  = 1'b0;
    sum_u       = {1'b0, a} + {1'b0, b};
    sum_s       = {a[SIZE-1], a} + {b[SIZE-1], b};
    case (command)
      CMD_AND:  op_result = {{SIZE{1'b0}}, a & b};
      CMD_OR:   op_result = {{SIZE{1'b0}}, a | b};
      CMD_XOR:  op_result = {{SIZE{1'b0}}, a ^ b};
      CMD_NOT:  op_result = {{SIZE{1'b0}}, ~a};
      CMD_ADD: begin
        op_result   = {{(SIZE-1){1'b0}}, sum_u};
        op_overflow = sum_u[SIZE];
      end
      CMD_ADDS: begin
        op_result   = {{(SIZE-1){sum_s[SIZE]}}, sum_s};
        op_overflow = (a[SIZE-1] == b[SIZE-1]) && (sum_s[SIZE-1] != a[SIZE-1]);
      end
      CMD_SUB: begin
        op_result   = {{SIZE{1'b0}}, a - b};
        op_overflow = (a < b);
      end
      CMD_MUL:  op_result = '0;
      CMD_CMPU: op_result[2:0] = {a > b, a == b, a < b};
      CMD_CMPS: op_result[2:0] = {$signed(a) > $signed(b), a == b,
                                  $signed(a) < $signed(b)};
      // Out-of-range shift amounts fall out of the widened operand as zero
      CMD_SHL:  op_result = {{SIZE{1'b0}}, a} << b;
      CMD_SHR:  op_result = {{SIZE{1'b0}}, a >> b};
      default:  op_illegal = (command > 4'(CMD_LAST_LEGAL));
    endcase
  end

  // Control FSM and output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            if (command == CMD_MUL) begin
              state     <= MUL;
              busy      <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              result    <= op_result;
              overflow  <= op_overflow;
              illegal   <= op_illegal;
              out_valid <= 1'b1;
            end
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          if (mul_done) begin
            result    <= mul_product;
            overflow  <= |mul_product[RW-1:SIZE];
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (SIZE=8): vector table streamed through a
// scoreboard, plus directed multiply, backpressure and reset sequences.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  command = '0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        overflow;
  logic        illegal;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [3:0]  cmd;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        ovf;
    logic        ill;
    int          stall;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        ill;
    int          id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  alu_seq #(.SIZE(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .command   (command),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y,
                              input logic [15:0] r, input logic o, input logic il, input int st);
    vec_t v;
    v.cmd = c; v.a = x; v.b = y; v.res = r; v.ovf = o; v.ill = il; v.stall = st;
    return v;
  endfunction

  // Drive one command (called at posedge+1); returns just after the accepting edge
  task automatic send(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y,
                      input logic push, input exp_t e, output int stalls);
    command  = c;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    stalls   = 0;
    @(negedge clk);
    while (!in_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 32'(stalls), 0);
    @(posedge clk);
    if (push) sb.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  // Scoreboard: compare every consumed result against the oldest expectation
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("result[%0d]", e.id), 32'(result), 32'(e.res));
        chk($sformatf("overflow[%0d]", e.id), 32'(overflow), 32'(e.ovf));
        chk($sformatf("illegal[%0d]", e.id), 32'(illegal), 32'(e.ill));
      end
    end
  end

  initial begin
    exp_t e;
    int   st;
    int   n;

    // Reset
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;

    // Vector table (stall = expected cycles in_ready held low before accept)
    vecs.push_back(mk(4'd0,  8'hF0, 8'h3C, 16'h0030, 0, 0, 0));
    vecs.push_back(mk(4'd1,  8'hF0, 8'h0F, 16'h00FF, 0, 0, 0));
    vecs.push_back(mk(4'd2,  8'hAA, 8'hFF, 16'h0055, 0, 0, 0));
    vecs.push_back(mk(4'd3,  8'h0F, 8'h00, 16'h00F0, 0, 0, 0));
    vecs.push_back(mk(4'd4,  8'hFF, 8'h01, 16'h0100, 1, 0, 0));
    vecs.push_back(mk(4'd4,  8'h10, 8'h20, 16'h0030, 0, 0, 0));
    vecs.push_back(mk(4'd5,  8'h7F, 8'h01, 16'h0080, 1, 0, 0));
    vecs.push_back(mk(4'd5,  8'h80, 8'hFF, 16'hFF7F, 1, 0, 0));
    vecs.push_back(mk(4'd5,  8'h05, 8'hFE, 16'h0003, 0, 0, 0));
    vecs.push_back(mk(4'd6,  8'h05, 8'h07, 16'h00FE, 1, 0, 0));
    vecs.push_back(mk(4'd6,  8'h07, 8'h05, 16'h0002, 0, 0, 0));
    vecs.push_back(mk(4'd8,  8'h80, 8'h01, 16'h0004, 0, 0, 0));
    vecs.push_back(mk(4'd9,  8'h80, 8'h01, 16'h0001, 0, 0, 0));
    vecs.push_back(mk(4'd9,  8'h42, 8'h42, 16'h0002, 0, 0, 0));
    vecs.push_back(mk(4'd10, 8'h81, 8'd4,  16'h0810, 0, 0, 0));
    vecs.push_back(mk(4'd10, 8'h01, 8'd15, 16'h8000, 0, 0, 0));
    vecs.push_back(mk(4'd10, 8'h01, 8'd16, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(4'd11, 8'h80, 8'd7,  16'h0001, 0, 0, 0));
    vecs.push_back(mk(4'd11, 8'hFF, 8'd8,  16'h0000, 0, 0, 0));
    vecs.push_back(mk(4'd7,  8'h0F, 8'h0D, 16'h00C3, 0, 0, 0));
    vecs.push_back(mk(4'd4,  8'h01, 8'h01, 16'h0002, 0, 0, 8));
    vecs.push_back(mk(4'd7,  8'hFF, 8'hFF, 16'hFE01, 1, 0, 0));
    vecs.push_back(mk(4'd13, 8'h12, 8'h34, 16'h0000, 0, 1, 8));
    vecs.push_back(mk(4'd12, 8'hFF, 8'hFF, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(4'd15, 8'h01, 8'h02, 16'h0000, 0, 1, 0));

    foreach (vecs[i]) begin
      e.res = vecs[i].res; e.ovf = vecs[i].ovf; e.ill = vecs[i].ill; e.id = i;
      send(vecs[i].cmd, vecs[i].a, vecs[i].b, 1'b1, e, st);
      chk($sformatf("stall[%0d]", i), 32'(st), 32'(vecs[i].stall));
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drained_out_valid", 32'(out_valid), 0);

    // Backpressure: result held, in_ready low, one-cycle latency
    out_ready = 1'b0;
    e.res = 16'h0100; e.ovf = 1'b1; e.ill = 1'b0; e.id = 100;
    send(4'd4, 8'hFF, 8'h01, 1'b1, e, st);
    chk("bp_latency_valid", 32'(out_valid), 1);
    chk("bp_latency_result", 32'(result), 32'h0100);
    chk("bp_latency_ovf", 32'(overflow), 1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_result", 32'(result), 32'h0100);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_cleared", 32'(out_valid), 0);

    // Multiply: busy for SIZE cycles, in_ready low throughout
    e.res = 16'hFE01; e.ovf = 1'b1; e.ill = 1'b0; e.id = 101;
    send(4'd7, 8'hFF, 8'hFF, 1'b1, e, st);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      chk("mul_in_ready", 32'(in_ready), 0);
    end
    chk("mul_busy_cycles", 32'(n), 8);
    chk("mul_out_valid", 32'(out_valid), 1);
    chk("mul_result", 32'(result), 32'hFE01);
    @(posedge clk);
    #1;

    // Reset mid-multiply aborts with no result
    e.res = 16'h0000; e.ovf = 1'b0; e.ill = 1'b0; e.id = 102;
    send(4'd7, 8'h12, 8'h34, 1'b0, e, st);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_result", 32'(result), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("abort_no_result", 32'(n), 0);
    chk("abort_idle_ready", 32'(in_ready), 1);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
